// File: rtl/uart_framer_pkg.sv
// uart_framer_pkg: shared definitions for the UART framer.
//   tx_state_t   - reply FSM states
//   CRC8_POLY    - CRC-8 generator polynomial (x^8 + x^2 + x + 1)
//   CRC8_INIT    - CRC-8 start value for each frame
//   MSGID_BYTES  - number of leading payload bytes that hold the message id
package uart_framer_pkg;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_LOAD = 2'd1,
        TX_SEND = 2'd2,
        TX_CRC  = 2'd3
    } tx_state_t;

    localparam logic [7:0] CRC8_POLY   = 8'h07;
    localparam logic [7:0] CRC8_INIT   = 8'h00;
    localparam int         MSGID_BYTES = 4;

endpackage

// File: rtl/uart_framer_crc8.sv
// uart_framer_crc8: combinational CRC-8 step, one byte per call, MSB first.
//   i_crc  - running CRC before this byte
//   i_byte - data byte
//   o_crc  - running CRC after this byte
module uart_framer_crc8
    import uart_framer_pkg::*;
(
    input  logic [7:0] i_crc,
    input  logic [7:0] i_byte,
    output logic [7:0] o_crc
);

    logic [7:0] w_acc;

    always_comb begin
        w_acc = i_crc ^ i_byte;
        for (int b = 0; b < 8; b++) begin
            w_acc = w_acc[7] ? ({w_acc[6:0], 1'b0} ^ CRC8_POLY) : {w_acc[6:0], 1'b0};
        end
        o_crc = w_acc;
    end

endmodule

// File: rtl/uart_framer.sv
// uart_framer: byte-stream frame receiver with automatic reply transmitter.
//   clk, rst_n    - single clock, asynchronous active-low reset
//   rx_byte/valid - received byte stream (one-cycle strobe per byte)
//   tx_byte/valid/ready - reply byte stream, transfer on valid & ready
//   tx_data       - reply payload, captured when a reply starts
//   rx_data       - payload of the last accepted frame
//   sync          - one-cycle pulse per accepted frame
//   frame_err     - one-cycle pulse per rejected frame
//   err_count     - saturating count of rejected frames
//   pkg_timeout   - high once TIMEOUT cycles pass without an accept
module uart_framer
    import uart_framer_pkg::*;
#(
    parameter int          BUFFER_SIZE = 80,
    parameter logic [31:0] MSGID       = 32'h74697277,
    parameter int          CHECK_MSGID = 1,
    parameter int          USE_CRC     = 1,
    parameter logic [31:0] TIMEOUT     = 32'd4800000,
    parameter logic [31:0] GAP_TIMEOUT = 32'd2400
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             rx_byte,
    input  logic                   rx_valid,
    output logic [7:0]             tx_byte,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    input  logic [BUFFER_SIZE-1:0] tx_data,
    output logic [BUFFER_SIZE-1:0] rx_data,
    output logic                   sync,
    output logic                   frame_err,
    output logic [7:0]             err_count,
    output logic                   pkg_timeout
);

    localparam int NPAY = BUFFER_SIZE / 8;
    localparam int NFRM = NPAY + ((USE_CRC != 0) ? 1 : 0);
    localparam int CW   = $clog2(NFRM + 1);

    // ---------------- RX path ----------------
    logic [CW-1:0]          r_rx_cnt;
    logic [BUFFER_SIZE-1:0] r_shift;
    logic [7:0]             r_rx_crc;
    logic [31:0]            r_gap;
    logic [BUFFER_SIZE-1:0] r_rx_data;
    logic                   r_sync;
    logic                   r_ferr;
    logic [7:0]             r_err_cnt;

    logic                   w_gap_exp;
    logic [CW-1:0]          w_cnt_eff;
    logic                   w_last;
    logic [7:0]             w_rx_crc_in;
    logic [7:0]             w_rx_crc_nxt;
    logic [BUFFER_SIZE-1:0] w_payload;
    logic                   w_id_ok;
    logic                   w_crc_ok;
    logic                   w_accept;
    logic                   w_reject;

    // A partial frame that has idled for GAP_TIMEOUT cycles is dropped; a byte
    // arriving in that same cycle is treated as the first byte of a new frame.
    assign w_gap_exp   = (r_rx_cnt != '0) && (r_gap >= GAP_TIMEOUT);
    assign w_cnt_eff   = w_gap_exp ? '0 : r_rx_cnt;
    assign w_last      = rx_valid && (w_cnt_eff == CW'(NFRM - 1));
    assign w_rx_crc_in = (w_cnt_eff == '0) ? CRC8_INIT : r_rx_crc;

    // Without a CRC byte the final byte is still payload and is not yet in r_shift.
    assign w_payload = (USE_CRC != 0) ? r_shift
                                      : {r_shift[BUFFER_SIZE-9:0], rx_byte};
    assign w_id_ok   = (CHECK_MSGID == 0) ||
                       (w_payload[BUFFER_SIZE-1 -: 8*MSGID_BYTES] == MSGID);
    assign w_crc_ok  = (USE_CRC == 0) || (rx_byte == r_rx_crc);
    assign w_accept  = w_last && w_id_ok && w_crc_ok;
    assign w_reject  = w_last && !(w_id_ok && w_crc_ok);

    uart_framer_crc8 u_rx_crc (
        .i_crc  (w_rx_crc_in),
        .i_byte (rx_byte),
        .o_crc  (w_rx_crc_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_cnt  <= '0;
            r_shift   <= '0;
            r_rx_crc  <= CRC8_INIT;
            r_gap     <= '0;
            r_rx_data <= '0;
            r_sync    <= 1'b0;
            r_ferr    <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_sync <= w_accept;
            r_ferr <= w_reject;
            if (rx_valid) begin
                r_gap    <= '0;
                r_rx_cnt <= w_last ? '0 : w_cnt_eff + 1'b1;
                if (w_cnt_eff < CW'(NPAY)) begin
                    r_shift  <= {r_shift[BUFFER_SIZE-9:0], rx_byte};
                    r_rx_crc <= w_rx_crc_nxt;
                end
            end else begin
                if (w_gap_exp) begin
                    r_rx_cnt <= '0;
                end
                r_gap <= ((r_rx_cnt == '0) || w_gap_exp) ? '0 : r_gap + 32'd1;
            end
            if (w_accept) begin
                r_rx_data <= w_payload;
            end
            if (w_reject && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    // ---------------- Watchdog ----------------
    logic [31:0] r_wd;
    logic        r_to;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wd <= '0;
            r_to <= 1'b0;
        end else if (w_accept) begin
            r_wd <= '0;
            r_to <= 1'b0;
        end else if (r_wd != TIMEOUT) begin
            r_wd <= r_wd + 32'd1;
            if (r_wd == TIMEOUT - 32'd1) begin
                r_to <= 1'b1;
            end
        end
    end

    // ---------------- TX reply FSM ----------------
    tx_state_t              r_state;
    tx_state_t              w_state_nxt;
    logic [BUFFER_SIZE-1:0] r_tx_buf;
    logic [7:0]             r_tx_crc;
    logic [7:0]             w_tx_crc_nxt;
    logic [CW-1:0]          r_tx_idx;
    logic                   r_pend;
    logic                   w_xfer;
    logic                   w_tx_last;
    logic                   w_more;
    logic                   w_frame_done;

    assign w_xfer       = tx_valid && tx_ready;
    assign w_tx_last    = (r_tx_idx == CW'(NPAY - 1));
    // Another reply is owed if one is pending or an accept lands right now.
    assign w_more       = r_pend || w_accept;
    assign w_frame_done = w_xfer && (((r_state == TX_SEND) && w_tx_last && (USE_CRC == 0)) ||
                                     (r_state == TX_CRC));

    uart_framer_crc8 u_tx_crc (
        .i_crc  (r_tx_crc),
        .i_byte (tx_byte),
        .o_crc  (w_tx_crc_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= TX_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            TX_IDLE: if (w_accept) w_state_nxt = TX_LOAD;
            TX_LOAD: w_state_nxt = TX_SEND;
            TX_SEND: begin
                if (w_xfer && w_tx_last) begin
                    if (USE_CRC != 0) w_state_nxt = TX_CRC;
                    else              w_state_nxt = w_more ? TX_LOAD : TX_IDLE;
                end
            end
            TX_CRC:  if (w_xfer) w_state_nxt = w_more ? TX_LOAD : TX_IDLE;
            default: w_state_nxt = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_valid = 1'b0;
        tx_byte  = 8'h00;
        case (r_state)
            TX_SEND: begin
                tx_valid = 1'b1;
                tx_byte  = r_tx_buf[BUFFER_SIZE-1 -: 8];
            end
            TX_CRC: begin
                tx_valid = 1'b1;
                tx_byte  = r_tx_crc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_buf <= '0;
            r_tx_crc <= CRC8_INIT;
            r_tx_idx <= '0;
            r_pend   <= 1'b0;
        end else begin
            if (r_state == TX_LOAD) begin
                r_tx_buf <= tx_data;
                r_tx_crc <= CRC8_INIT;
                r_tx_idx <= '0;
            end else if ((r_state == TX_SEND) && w_xfer) begin
                r_tx_buf <= {r_tx_buf[BUFFER_SIZE-9:0], 8'h00};
                r_tx_crc <= w_tx_crc_nxt;
                r_tx_idx <= r_tx_idx + 1'b1;
            end
            // Finishing a frame consumes any owed reply (the FSM goes to LOAD);
            // extra accepts while one is already owed collapse into it.
            if (w_frame_done) begin
                r_pend <= 1'b0;
            end else if (w_accept && (r_state != TX_IDLE)) begin
                r_pend <= 1'b1;
            end
        end
    end

    assign rx_data     = r_rx_data;
    assign sync        = r_sync;
    assign frame_err   = r_ferr;
    assign err_count   = r_err_cnt;
    assign pkg_timeout = r_to;

endmodule

// File: tb/tb_uart_framer.sv
// tb_uart_framer: directed checks of the UART framer (receive, reject, gap
// abort, back-pressured reply with pending frame, watchdog, reset mid-reply).
module tb_uart_framer;

    localparam int BS = 80;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic          rx_valid = 1'b0;
    logic [7:0]    tx_byte;
    logic          tx_valid;
    logic          tx_ready = 1'b1;
    logic [BS-1:0] tx_data = '0;
    logic [BS-1:0] rx_data;
    logic          sync;
    logic          frame_err;
    logic [7:0]    err_count;
    logic          pkg_timeout;

    uart_framer #(.BUFFER_SIZE(BS), .TIMEOUT(32'd100)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .tx_byte     (tx_byte),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .rx_data     (rx_data),
        .sync        (sync),
        .frame_err   (frame_err),
        .err_count   (err_count),
        .pkg_timeout (pkg_timeout)
    );

    always #5 clk = ~clk;

    localparam logic [BS-1:0] F1  = 80'h74697277_112233445566;
    localparam logic [BS-1:0] F2  = 80'h74697277_A5A50F0FF0F0;
    localparam logic [BS-1:0] BAD = 80'h00697277_112233445566;
    localparam logic [BS-1:0] T1  = 80'hDEADBEEF_0123456789AB;
    localparam logic [BS-1:0] T2  = 80'hCAFEF00D_13579BDF2468;

    int npass = 0;
    int nfail = 0;
    int nchk  = 0;
    int cyc   = 0;
    int n_sync = 0;
    logic [7:0] q[$];
    int         qc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Transfers and pulses are observed mid-cycle, away from the clock edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_valid && tx_ready) begin
                q.push_back(tx_byte);
                qc.push_back(cyc);
            end
            if (sync) n_sync++;
        end
    end

    function automatic logic [7:0] byte_of(logic [BS-1:0] v, int i);
        return v[BS-1-8*i -: 8];
    endfunction

    function automatic logic [7:0] crc_of(logic [BS-1:0] v);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < BS/8; i++) begin
            c = c ^ byte_of(v, i);
            for (int b = 0; b < 8; b++)
                c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    task automatic chk(string tag, logic [BS-1:0] obs, logic [BS-1:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_payload(logic [BS-1:0] p);
        for (int i = 0; i < BS/8; i++) send_byte(byte_of(p, i));
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_q(int n, int max);
        for (int i = 0; i < max && q.size() < n; i++) tick();
        chk("reply_wait", BS'(q.size() >= n), BS'(1));
    endtask

    task automatic chk_reply(int base, logic [BS-1:0] t);
        for (int i = 0; i < BS/8 + 1; i++)
            chk("reply_byte", BS'(q[base+i]), BS'((i < BS/8) ? byte_of(t, i) : crc_of(t)));
    endtask

    initial begin
        int b0, ns;
        logic [7:0] held;

        // Reset state
        repeat (2) tick();
        chk("rst_tx_valid", BS'(tx_valid), BS'(0));
        chk("rst_tx_byte", BS'(tx_byte), BS'(0));
        chk("rst_sync", BS'(sync), BS'(0));
        chk("rst_frame_err", BS'(frame_err), BS'(0));
        chk("rst_err_count", BS'(err_count), BS'(0));
        chk("rst_timeout", BS'(pkg_timeout), BS'(0));
        chk("rst_rx_data", rx_data, '0);
        do_reset();

        // Watchdog: high exactly at cycle 100 after release
        repeat (99) tick();
        chk("wd_cycle99", BS'(pkg_timeout), BS'(0));
        tick();
        chk("wd_cycle100", BS'(pkg_timeout), BS'(1));

        // Good frame: accept, timeout cleared with sync, back-to-back reply
        tx_data = T1;
        b0 = q.size();
        send_payload(F1);
        chk("wd_held", BS'(pkg_timeout), BS'(1));
        send_byte(crc_of(F1));
        chk("good_sync", BS'(sync), BS'(1));
        chk("good_wd_clear", BS'(pkg_timeout), BS'(0));
        chk("good_rx_data", rx_data, F1);
        tick();
        chk("sync_one_cycle", BS'(sync), BS'(0));
        wait_q(b0 + 11, 40);
        chk_reply(b0, T1);
        chk("reply_b2b", BS'(qc[b0+10] - qc[b0]), BS'(10));

        // Bad MSGID: reject, no reply, rx_data kept
        b0 = q.size();
        send_payload(BAD);
        send_byte(crc_of(BAD));
        chk("bad_frame_err", BS'(frame_err), BS'(1));
        chk("bad_sync", BS'(sync), BS'(0));
        chk("bad_err_count", BS'(err_count), BS'(1));
        chk("bad_rx_data", rx_data, F1);
        repeat (20) tick();
        chk("bad_no_reply", BS'(q.size()), BS'(b0));
        chk("bad_tx_valid", BS'(tx_valid), BS'(0));

        // Gap abort: partial frame silently discarded
        do_reset();
        chk("gap_err_rst", BS'(err_count), BS'(0));
        for (int i = 0; i < 5; i++) send_byte(byte_of(F1, i));
        repeat (2401) tick();
        ns = n_sync;
        b0 = q.size();
        tx_data = T2;
        send_payload(F2);
        send_byte(crc_of(F2));
        repeat (2) tick();
        chk("gap_one_sync", BS'(n_sync - ns), BS'(1));
        chk("gap_err_count", BS'(err_count), BS'(0));
        chk("gap_rx_data", rx_data, F2);
        wait_q(b0 + 11, 40);

        // Back-pressure mid-reply with a second frame arriving
        b0 = q.size();
        ns = n_sync;
        tx_data = T1;
        send_payload(F1);
        send_byte(crc_of(F1));
        repeat (3) tick();
        tx_ready = 1'b0;
        tx_data  = T2;
        held = tx_byte;
        chk("bp_held_byte", BS'(held), BS'(byte_of(T1, 2)));
        for (int k = 0; k < 50; k++) begin
            if (k < 11) begin
                rx_byte  = (k < 10) ? byte_of(F2, k) : crc_of(F2);
                rx_valid = 1'b1;
            end else begin
                rx_valid = 1'b0;
            end
            tick();
            chk("bp_stable", BS'(tx_byte), BS'(held));
        end
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        wait_q(b0 + 22, 100);
        chk_reply(b0, T1);
        chk_reply(b0 + 11, T2);
        chk("bp_pend_gap", BS'(qc[b0+11] - qc[b0+10]), BS'(2));
        chk("bp_two_sync", BS'(n_sync - ns), BS'(2));

        // Reset during the 4th reply byte
        b0 = q.size();
        tx_data = T1;
        send_payload(F1);
        send_byte(crc_of(F1));
        repeat (4) tick();
        chk("rr_at_byte4", BS'(tx_byte), BS'(byte_of(T1, 3)));
        rst_n = 1'b0;
        #1;
        chk("rr_valid_low", BS'(tx_valid), BS'(0));
        chk("rr_byte_low", BS'(tx_byte), BS'(0));
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rr_after_release", BS'(tx_valid), BS'(0));
        repeat (30) tick();
        chk("rr_no_residual", BS'(q.size()), BS'(b0 + 3));

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/uart_framer.md
UART_FRAMER -- requirements
Module: uart_framer

Interface
REQ-001 SHALL have parameter BUFFER_SIZE, default 80, frame payload bits (multiple of 8, at least 40).
REQ-002 SHALL have parameter MSGID, default 32'h74697277, expected value of the first 4 payload bytes.
REQ-003 SHALL have parameter CHECK_MSGID, default 1, which enables MSGID comparison.
REQ-004 SHALL have parameter USE_CRC, default 1, which appends a CRC-8 byte to both RX and TX frames.
REQ-005 SHALL have parameter TIMEOUT, default 32'd4800000, watchdog cycles without a good frame.
REQ-006 SHALL have parameter GAP_TIMEOUT, default 32'd2400, idle cycles that abort a partial frame.
REQ-007 SHALL have ports, clock and reset first: clk in 1, single clock; rst_n in 1, asynchronous active-low reset.
REQ-008 SHALL have ports rx_byte in 8, received byte; rx_valid in 1, one-cycle strobe.
REQ-009 SHALL have ports tx_byte out 8; tx_valid out 1; tx_ready in 1; a byte transfers when tx_valid and tx_ready are both high.
REQ-010 SHALL have ports tx_data in BUFFER_SIZE, reply payload; rx_data out BUFFER_SIZE, last accepted payload.
REQ-011 SHALL have ports sync out 1, accept pulse; frame_err out 1, reject pulse; err_count out 8; pkg_timeout out 1.

Function
REQ-012 RX SHALL shift bytes MSB-first; frame length N = BUFFER_SIZE/8 + USE_CRC.
REQ-013 On the Nth byte, the frame SHALL be accepted only if the MSGID matches (when CHECK_MSGID) and the CRC is good (when USE_CRC).
REQ-014 Accept SHALL load rx_data and pulse sync for exactly one cycle, the cycle after the Nth rx_valid.
REQ-015 Reject SHALL pulse frame_err for one cycle, leave rx_data unchanged, send no reply, and increment err_count, saturating at 255.
REQ-016 CRC-8 SHALL use polynomial 0x07, init 0x00, and be computed over payload bytes only, one byte per cycle.
REQ-017 When the RX byte counter is nonzero and no rx_valid arrives for GAP_TIMEOUT cycles, the counter SHALL clear silently, with no err_count change.
REQ-018 The TX FSM SHALL have states IDLE, LOAD, SEND and CRC.
REQ-019 On accept, the TX FSM SHALL go IDLE->LOAD, capturing tx_data; tx_valid SHALL rise the next cycle.
REQ-020 In SEND, the FSM SHALL present bytes MSB-first, holding tx_byte stable until tx_ready, then advance.
REQ-021 After the last payload byte, the FSM SHALL go to CRC if USE_CRC (sending the TX CRC) and otherwise to IDLE.
REQ-022 RX SHALL run full-duplex during TX.
REQ-023 An accept during a non-IDLE TX state SHALL set a one-deep pending flag; the FSM SHALL enter LOAD directly after the current frame; a further accept while pending SHALL be merged.
REQ-024 The watchdog SHALL count cycles since the last accept; pkg_timeout SHALL go high when the count reaches TIMEOUT, stay high, clear on the cycle of the next accept, and the counter SHALL saturate.
REQ-025 rx_valid on the same cycle as gap expiry SHALL count as byte 1 of a new frame.

Reset
REQ-026 rst_n low SHALL asynchronously clear rx_data, tx_byte, tx_valid, sync, frame_err, err_count, pkg_timeout, all counters, the pending flag, and the CRC; the TX FSM SHALL return to IDLE.
REQ-027 Reset mid-frame SHALL abort RX and TX; after release, the block SHALL wait for a fresh frame, and tx_valid SHALL be 0 the first cycle after release.

Structure
REQ-028 A shared package uart_framer_pkg SHALL hold the TX state enum, CRC polynomial/init constants, and the MSGID byte width (4).
REQ-029 A combinational sub-module uart_framer_crc8 SHALL compute next CRC from (crc, byte), instanced once for RX and once for TX.
REQ-030 The UART PHY SHALL stay outside this block; wrappers connect rx_byte/rx_valid and tx_byte/tx_valid/tx_ready.

Verification
REQ-031 Test 1: a good 10-byte frame with the MSGID prefix and a correct CRC, tx_ready always 1 -> sync pulses once, rx_data equals the frame, and 11 bytes equal to tx_data+CRC are sent back-to-back.
REQ-032 Test 2: a frame with the first byte 0x00 -> frame_err pulses, err_count=1, rx_data unchanged, tx_valid stays 0.
REQ-033 Test 3: 5 bytes, then an idle gap of 2401 cycles, then a full good frame -> exactly one sync and err_count=0.
REQ-034 Test 4: tx_ready held low 50 cycles mid-reply while a second good frame arrives -> tx_byte stays stable, and the second reply starts immediately after the first CRC byte.
REQ-035 Test 5: TIMEOUT=100 with no frames -> pkg_timeout=1 at cycle 100; a good frame clears it the same cycle sync pulses.
REQ-036 Test 6: rst_n dropped during byte 4 of a reply -> tx_valid=0 immediately, and no residual bytes follow release.
